pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the arithmetic datapath, built from GROUP-bit lookahead slices. The carry ripples between slices through pipeline registers, one slice per stage. This gives one result per cycle at any WIDTH, with fixed latency. A valid/ready handshake on both sides lets it sit between a producer and a consumer that can stall.

## Interface
- WIDTH, 16: operand/sum width in bits; must be a multiple of GROUP and ≥ GROUP.
- GROUP, 4: bits per lookahead slice; NG = WIDTH/GROUP slices, which is also the number of pipeline stages.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand word offered.
- in_ready  output  1  block accepts the word this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_ci  input  1  carry-in; add mode only.
- in_sub  input  1  1 = compute A − B, 0 = compute A + B + ci.
- out_valid  output  1  result word present.
- out_ready  input  1  consumer takes the result this cycle.
- out_sum  output  WIDTH  sum/difference, modulo 2^WIDTH.
- out_co  output  1  carry out of the MSB; in subtract mode, 1 = no borrow.
- out_ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Accept condition: in_valid && in_ready at a rising edge.
- Subtract mode: the B operand is bitwise inverted and the effective carry-in is forced to 1; in_ci is ignored.
- Stage k (k = 0..NG−1):
  - Computes slice k from its carry-in and the operand bits for slice k.
  - Registers the completed sum bits [GROUP·(k+1)−1:0], the slice carry-out, the still-unused operand bits, and a valid bit.
- Slice k sum = P ^ {carries}. Internal carries use lookahead: c[i+1] = g[i] | p[i]&c[i], fully expanded within the slice. There is no ripple inside a slice.
- Pipeline-wide advance enable: adv = !out_valid || out_ready. All stages shift together when adv = 1 and hold when adv = 0. There are no bubbles-collapse rules; empty stages shift like full ones.
- in_ready = adv && !rst. This is combinational from out_valid and out_ready only; it never depends on in_valid.
- out_sum, out_co and out_ovf are driven from the last stage registers only. They hold stable while out_valid && !out_ready.
- Results leave in acceptance order. Nothing is dropped or duplicated.
- Reset (synchronous, any time, including mid-operation):
  - All stage valid bits clear at the next edge.
  - out_valid = 0, out_sum = 0, out_co = 0, out_ovf = 0.
  - In-flight words are discarded.
  - in_ready is 0 during any cycle in which rst is high.

## Timing
- Latency: a word accepted at edge e appears with out_valid = 1 after edge e+NG−1 if no stall occurs. With the defaults (NG = 4), a word accepted at edge 0 becomes visible after edge 3.
- Throughput: one word per cycle while out_ready stays 1.
- Stall: out_valid && !out_ready freezes every stage and drives in_ready to 0 in the same cycle. On the cycle out_ready returns to 1, the output is consumed and a new word may be accepted at the same edge.
- Simultaneous accept and consume at the same edge is legal and required at full throughput.
- Critical path: one GROUP-bit lookahead slice plus the stage register; it is independent of WIDTH.

## Structure
- Package cla_pkg holds:
  - function num_groups(WIDTH, GROUP).
  - A static assertion helper for WIDTH % GROUP == 0.
  - A typedef for the per-stage record: valid, partial sum, remaining A/B, carry.
- Sub-module cla_group: a combinational GROUP-bit lookahead slice.
  - Inputs a, b, ci.
  - Outputs s, co, plus group P and group G for future two-level lookahead.
  - Also outputs c_msb (carry into the slice MSB), used for ovf in the last slice.
- The top level instantiates NG cla_group slices, the stage registers and the advance logic.

## Test plan
- Defaults; add 0xFFFF + 0x0001, ci = 0, out_ready = 1 → after 4 cycles out_sum = 0x0000, out_co = 1, out_ovf = 0.
- Add 0x7FFF + 0x0001 → out_sum = 0x8000, out_co = 0, out_ovf = 1.
- Subtract 0x0005 − 0x0007 with in_ci = 1 (ignored) → out_sum = 0xFFFE, out_co = 0, out_ovf = 0. Then 0x8000 − 0x0001 → out_sum = 0x7FFF, out_co = 1, out_ovf = 1.
- Stream 8 back-to-back words and hold out_ready low for 3 cycles after the first result. Required response:
  - in_ready is low in exactly those cycles.
  - Outputs stay frozen during the stall.
  - All 8 results arrive in order with none lost or repeated.
  - Total time is 4 + 8 + 3 − 1 cycles.
- With 3 words in flight, assert rst for 1 cycle → out_valid = 0 and all outputs 0 after that edge. No stale word ever emerges, and a word accepted after reset emerges 4 cycles later with the correct sum.
- Parameter sweep over WIDTH/GROUP = 8/2, 16/4, 32/8 and 12/12. Run 2000 random add/sub words per setting with random out_ready; compare against a behavioural model, checking sum, co and ovf bit-exact.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: slice/stage count
// and the parameter legality check used at elaboration.
package cla_pkg;

  function automatic int num_groups(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit width_ok(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Producer/consumer handshake bundle for pipelined_cla_adder.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ci;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_co, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_co, out_ovf
  );
endinterface

// File: rtl/pipelined_cla_adder_group.sv
// Combinational GROUP-bit carry-lookahead slice; every internal carry is a flat
// sum of products of g/p terms, so there is no ripple inside the slice.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             ci_i,
  output logic [GROUP-1:0] s_o,
  output logic             co_o,
  output logic             p_o,
  output logic             g_o,
  output logic             c_msb_o
);
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   gen;
  logic [GROUP:0]   prop;
  logic [GROUP:0]   c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // gen[i]: carry into bit i generated inside the slice; prop[i]: ci reaches bit i
  always_comb begin
    logic term;
    term    = 1'b0;
    gen     = '0;
    prop    = '0;
    prop[0] = 1'b1;
    for (int i = 1; i <= GROUP; i++) begin
      prop[i] = prop[i-1] & p[i-1];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        gen[i] = gen[i] | term;
      end
    end
  end

  assign c       = gen | ({(GROUP+1){ci_i}} & prop);
  assign s_o     = p ^ c[GROUP-1:0];
  assign co_o    = c[GROUP];
  assign c_msb_o = c[GROUP-1];
  assign p_o     = prop[GROUP];
  assign g_o     = gen[GROUP];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one lookahead slice per stage, the carry and the
// unconsumed operand bits travel down the pipeline with the partial sum.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int NG = num_groups(WIDTH, GROUP);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
  } stage_t;

  if (!width_ok(WIDTH, GROUP)) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  logic adv;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv && !rst;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    localparam int REM_IN  = WIDTH - k * GROUP;
    localparam int REM_OUT = REM_IN - GROUP;

    logic [REM_IN-1:0] a_in;
    logic [REM_IN-1:0] b_in;
    logic              ci_in;
    logic              valid_in;
    logic [WIDTH-1:0]  sum_in;
    logic [GROUP-1:0]  s;
    logic              co;
    logic              c_msb;
    stage_t            st_d;
    stage_t            st_q;

    // Subtraction is folded in at the head: B inverted, carry-in forced high
    if (k == 0) begin : g_head
      assign a_in     = bus.in_a;
      assign b_in     = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign ci_in    = bus.in_sub | bus.in_ci;
      assign valid_in = bus.in_valid && bus.in_ready;
      assign sum_in   = '0;
    end else begin : g_body
      assign a_in     = g_stage[k-1].g_rem.a_q;
      assign b_in     = g_stage[k-1].g_rem.b_q;
      assign ci_in    = g_stage[k-1].st_q.carry;
      assign valid_in = g_stage[k-1].st_q.valid;
      assign sum_in   = g_stage[k-1].st_q.sum;
    end

    cla_group #(.GROUP(GROUP)) u_group (
      .a_i     (a_in[GROUP-1:0]),
      .b_i     (b_in[GROUP-1:0]),
      .ci_i    (ci_in),
      .s_o     (s),
      .co_o    (co),
      .p_o     (),
      .g_o     (),
      .c_msb_o (c_msb)
    );

    always_comb begin
      st_d       = '0;
      st_d.valid = valid_in;
      st_d.carry = co;
      st_d.sum   = sum_in;
      st_d.sum[k*GROUP +: GROUP] = s;
    end

    always_ff @(posedge clk) begin
      if (rst)      st_q <= '0;
      else if (adv) st_q <= st_d;
    end

    if (REM_OUT > 0) begin : g_rem
      logic [REM_OUT-1:0] a_q;
      logic [REM_OUT-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[REM_IN-1:GROUP];
          b_q <= b_in[REM_IN-1:GROUP];
        end
      end
    end

    if (k == NG - 1) begin : g_tail
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= c_msb ^ co;
      end
    end
  end

  assign bus.out_valid = g_stage[NG-1].st_q.valid;
  assign bus.out_sum   = g_stage[NG-1].st_q.sum;
  assign bus.out_co    = g_stage[NG-1].st_q.carry;
  assign bus.out_ovf   = g_stage[NG-1].g_tail.ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors, stall/reset sequences on a
// 16/4 instance, and randomized handshake traffic on four WIDTH/GROUP settings.
module tb_pipelined_cla_adder;
  localparam int W      = 16;
  localparam int G      = 4;
  localparam int NG     = W / G;
  localparam int N_RAND = 2000;

  typedef struct packed {
    logic        co;
    logic        ovf;
    logic [63:0] sum;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] sum;
    logic        co;
    logic        ovf;
    string       name;
  } vec_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic sw_rst = 1'b1;
  int   tests  = 0;
  int   fails  = 0;
  bit   sw_done [4];

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(W)) m ();
  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) u_dut (.clk(clk), .rst(rst), .bus(m.slave));

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: unsigned and signed integer arithmetic on w-bit operands
  function automatic res_t ref_calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic ci, input logic sub);
    longint unsigned mask, ua, ub, full;
    longint          sa, sb, sr, smax, smin;
    res_t            r;
    mask = (64'd1 << w) - 64'd1;
    ua   = a & mask;
    ub   = b & mask;
    sa   = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
    sb   = ((ub >> (w - 1)) != 0) ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
    smax = longint'(mask >> 1);
    smin = -smax - 1;
    if (sub) begin
      full = (ua - ub) & mask;
      r.co = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub + 64'(ci);
      r.co = ((full >> w) & 64'd1) != 0;
      full = full & mask;
      sr   = sa + sb + longint'(ci);
    end
    r.ovf = (sr > smax) || (sr < smin);
    r.sum = full;
    return r;
  endfunction

  function automatic logic [65:0] dut_out();
    return {m.out_co, m.out_ovf, 64'(m.out_sum)};
  endfunction

  task automatic send_check(input vec_t v);
    int lat;
    lat = -1;
    @(negedge clk);
    m.in_valid  = 1'b1;
    m.in_a      = v.a;
    m.in_b      = v.b;
    m.in_ci     = v.ci;
    m.in_sub    = v.sub;
    m.out_ready = 1'b1;
    #1 chk({v.name, "_in_ready"}, 66'(m.in_ready), 66'(1));
    @(posedge clk);
    @(negedge clk);
    m.in_valid = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      if (m.out_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    chk({v.name, "_latency"}, 66'(lat), 66'(NG - 1));
    chk(v.name, dut_out(), {v.co, v.ovf, 64'(v.sum)});
  endtask

  vec_t        vecs [10];
  vec_t        post;
  res_t        exp_q [$];
  logic [65:0] frozen;
  logic [15:0] ra, rb;
  int          sent, got, stall, low_cnt, done_cyc, stale;
  bit          all_done;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap"};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf"};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "add_ci"};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_negovf"};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_zero"};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "add_ones_ci"};
    vecs[8] = '{16'h0001, 16'h8000, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, "sub_minneg"};
    vecs[9] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "add_slicecarry"};
    post    = '{16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0, "post_rst"};

    // Reset: offered words must not be accepted, outputs all zero
    m.in_valid = 1'b1; m.in_a = 16'hABCD; m.in_b = 16'h1234;
    m.in_ci = 1'b0; m.in_sub = 1'b0; m.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 66'(m.in_ready), 66'(0));
    chk("rst_outputs", {m.out_valid, m.out_co, m.out_ovf, 63'(m.out_sum)}, 66'(0));
    rst = 1'b0; sw_rst = 1'b0; m.in_valid = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (m.out_valid) stale++;
    end
    chk("rst_no_output", 66'(stale), 66'(0));

    for (int i = 0; i < 10; i++) send_check(vecs[i]);

    // 8 back-to-back words, out_ready low for 3 cycles once the first result shows
    @(negedge clk);
    sent = 0; got = 0; stall = 0; low_cnt = 0; done_cyc = -1; frozen = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (sent < 8) begin
        ra = 16'($urandom); rb = 16'($urandom);
        m.in_valid = 1'b1; m.in_a = ra; m.in_b = rb;
        m.in_ci = 1'($urandom); m.in_sub = 1'($urandom);
      end else begin
        m.in_valid = 1'b0;
      end
      if (m.out_valid && stall < 3) begin
        m.out_ready = 1'b0;
        stall++;
      end else begin
        m.out_ready = 1'b1;
      end
      #1;
      chk("stall_in_ready", 66'(m.in_ready), 66'(!(m.out_valid && !m.out_ready)));
      if (!m.in_ready) low_cnt++;
      if (m.out_valid && !m.out_ready) begin
        if (stall == 1) frozen = dut_out();
        else chk("stall_frozen", dut_out(), frozen);
      end
      if (m.out_valid && m.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_out", 66'(1), 66'(exp_q.size()));
        end else begin
          chk("stream_result", dut_out(), exp_q.pop_front());
        end
        got++;
        if (got == 8) done_cyc = cyc;
      end
      if (m.in_valid && m.in_ready) begin
        exp_q.push_back(ref_calc(W, 64'(m.in_a), 64'(m.in_b), m.in_ci, m.in_sub));
        sent++;
      end
      @(negedge clk);
    end
    m.in_valid = 1'b0;
    chk("stream_count", 66'(got), 66'(8));
    chk("stream_ready_low", 66'(low_cnt), 66'(3));
    chk("stream_total", 66'(done_cyc), 66'(4 + 8 + 3 - 1));
    chk("stream_leftover", 66'(exp_q.size()), 66'(0));

    // Reset with three words in flight
    for (int i = 0; i < 3; i++) begin
      m.in_valid = 1'b1; m.in_a = 16'hFFFF; m.in_b = 16'hFFFF;
      m.in_ci = 1'b1; m.in_sub = 1'b0; m.out_ready = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    #1 chk("rst_mid_in_ready", 66'(m.in_ready), 66'(0));
    @(negedge clk);
    rst = 1'b0; m.in_valid = 1'b0;
    chk("rst_mid_clear", {m.out_valid, m.out_co, m.out_ovf, 63'(m.out_sum)}, 66'(0));
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (m.out_valid) stale++;
    end
    chk("rst_mid_stale", 66'(stale), 66'(0));
    send_check(post);
    @(negedge clk);

    all_done = 1'b0;
    for (int i = 0; i < 30000 && !all_done; i++) begin
      all_done = sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3];
      if (!all_done) @(negedge clk);
    end
    chk("sweep_done", 66'(all_done), 66'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic int sw_width(input int g);
    case (g)
      0:       return 8;
      1:       return 16;
      2:       return 32;
      default: return 12;
    endcase
  endfunction

  function automatic int sw_group(input int g);
    case (g)
      0:       return 2;
      1:       return 4;
      2:       return 8;
      default: return 12;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int SW = sw_width(g);
    localparam int SG = sw_group(g);

    pipelined_cla_adder_if #(.WIDTH(SW)) sb ();
    pipelined_cla_adder #(.WIDTH(SW), .GROUP(SG)) u_dut (.clk(clk), .rst(sw_rst), .bus(sb.slave));

    initial begin
      res_t        q [$];
      logic [63:0] xa, xb;
      int          acc, cons, cyc;
      acc = 0; cons = 0; cyc = 0;
      sb.in_valid = 1'b0; sb.in_a = '0; sb.in_b = '0;
      sb.in_ci = 1'b0; sb.in_sub = 1'b0; sb.out_ready = 1'b1;
      wait (!sw_rst);
      while (acc < N_RAND || q.size() != 0) begin
        if (cyc > 20000) begin
          chk($sformatf("sweep%0d_timeout", SW), 66'(cons), 66'(N_RAND));
          break;
        end
        @(negedge clk);
        cyc++;
        sb.out_ready = ($urandom_range(0, 9) < 7) || (acc >= N_RAND);
        if (acc < N_RAND && $urandom_range(0, 3) != 0) begin
          xa = {$urandom, $urandom};
          xb = {$urandom, $urandom};
          if ($urandom_range(0, 7) == 0) xa = '1;
          if ($urandom_range(0, 7) == 0) xb = '0;
          sb.in_valid = 1'b1;
          sb.in_a     = xa[SW-1:0];
          sb.in_b     = xb[SW-1:0];
          sb.in_ci    = 1'($urandom);
          sb.in_sub   = 1'($urandom);
        end else begin
          sb.in_valid = 1'b0;
        end
        #1;
        if (sb.out_valid && sb.out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("sweep%0d_extra_out", SW), 66'(1), 66'(q.size()));
          end else begin
            chk($sformatf("sweep%0d_result", SW),
                {sb.out_co, sb.out_ovf, 64'(sb.out_sum)}, q.pop_front());
          end
          cons++;
        end
        if (sb.in_valid && sb.in_ready) begin
          q.push_back(ref_calc(SW, 64'(sb.in_a), 64'(sb.in_b), sb.in_ci, sb.in_sub));
          acc++;
        end
      end
      sb.in_valid = 1'b0;
      chk($sformatf("sweep%0d_count", SW), 66'(cons), 66'(N_RAND));
      sw_done[g] = 1'b1;
    end
  end
endmodule
